// File: rtl/alien_pkg.sv
// Shared invader-grid geometry and fleet state encoding.
// Imported by alien_extent, alien_fleet_ctrl and the alien renderer.
package alien_pkg;

  localparam int ROWS      = 5;
  localparam int COLS      = 8;
  localparam int ALIEN_W   = 16;
  localparam int ALIEN_H   = 16;
  localparam int SPACING_X = 24;
  localparam int SPACING_Y = 20;
  localparam int N_ALIENS  = ROWS * COLS;

  localparam int RESTART_FRAMES = 120;

  typedef enum logic [1:0] {
    S_MARCH_R,
    S_MARCH_L,
    S_CLEARED,
    S_LANDED
  } fleet_state_t;

endpackage

// File: rtl/alien_extent.sv
// Live-fleet extents: leftmost/rightmost occupied column and lowest
// occupied row, all derived combinationally from the alive mask.
module alien_extent
  import alien_pkg::*;
(
  input  logic [N_ALIENS-1:0] alive_i,
  output logic [2:0]          left_col_o,
  output logic [2:0]          right_col_o,
  output logic [2:0]          bot_row_o
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  // Occupancy per column/row, then priority-encode each end.
  always_comb begin
    col_any     = '0;
    row_any     = '0;
    left_col_o  = '0;
    right_col_o = '0;
    bot_row_o   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_i[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_any[c]) left_col_o = 3'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_any[c]) right_col_o = 3'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_any[r]) bot_row_o = 3'(r);
    end
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Fleet march/drop controller with alive mask and clear/land flags.
// Optional ALIEN_WAVE_RESTART_EN reloads a new wave after a clear.
module alien_fleet_ctrl
  import alien_pkg::*;
#(
  parameter int START_X      = 64,
  parameter int START_Y      = 48,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 8,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int LAND_Y       = 440,
  parameter int MIN_PERIOD   = 2,
  parameter int PERIOD_SHIFT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                hit_valid,
  input  logic [2:0]          hit_row,
  input  logic [2:0]          hit_col,
  output logic [9:0]          fleet_x,
  output logic [9:0]          fleet_y,
  output logic [N_ALIENS-1:0] alive,
  output logic [5:0]          alive_count,
  output logic                anim_frame,
  output logic                fleet_dir,
  output logic                march_tick,
  output logic                fleet_cleared,
  output logic                fleet_landed
);

  localparam logic [5:0] FULL_CNT  = 6'(N_ALIENS);
  localparam logic [6:0] RESET_PER =
    7'(MIN_PERIOD + (N_ALIENS >> PERIOD_SHIFT));

  fleet_state_t          state_q, state_d;
  logic                  frame_q;
  logic [9:0]            x_q, x_d, y_q, y_d;
  logic [N_ALIENS-1:0]   alive_q, alive_d;
  logic [5:0]            count_q, count_d;
  logic                  anim_q, anim_d;
  logic                  dir_q, dir_d;
  logic                  tick_q, tick_d;
  logic                  clr_q, clr_d;
  logic                  land_q, land_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [6:0]            per_q, per_d;

  logic                  frame_tick;
  logic [5:0]            hit_idx;
  logic                  hit_ok;
  logic                  at_period;
  logic [2:0]            left_col, right_col, bot_row;
  logic [11:0]           right_px;
  logic signed [11:0]    left_px;
  logic [9:0]            y_drop;
  logic [11:0]           bot_px;
  logic                  drop;
  logic                  landing;

  alien_extent u_extent (
    .alive_i     (alive_q),
    .left_col_o  (left_col),
    .right_col_o (right_col),
    .bot_row_o   (bot_row)
  );

  assign frame_tick = frame_clk & ~frame_q;
  assign hit_idx    = 6'(hit_row) * 6'(COLS) + 6'(hit_col);
  assign hit_ok     = hit_valid && (hit_row < 3'(ROWS))
                    && alive_q[hit_idx];
  assign at_period  = (cnt_q == per_q - 7'd1);

  // Edge tests use the pre-hit mask; left test is signed so x-2 < 0 holds.
  assign right_px = {2'b00, x_q}
                  + 12'(right_col) * 12'(SPACING_X)
                  + 12'(ALIEN_W - 1 + STEP_X);
  assign left_px  = $signed({2'b00, x_q}
                  + 12'(left_col) * 12'(SPACING_X)
                  - 12'(STEP_X));
  assign y_drop   = y_q + 10'(STEP_Y);
  assign bot_px   = {2'b00, y_drop}
                  + 12'(bot_row) * 12'(SPACING_Y)
                  + 12'(ALIEN_H - 1);
  assign landing  = (bot_px >= 12'(LAND_Y));
  assign drop     = (state_q == S_MARCH_L)
                  ? (left_px < $signed(12'(X_MIN)))
                  : (right_px > 12'(X_MAX));

  // Next-state: hits, march steps, drops, clear and land transitions.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    alive_d = alive_q;
    count_d = count_q;
    anim_d  = anim_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    clr_d   = clr_q;
    land_d  = land_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    unique case (state_q)
      S_MARCH_R, S_MARCH_L: begin
        if (count_q == '0) begin
          state_d = S_CLEARED;
          clr_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          if (hit_ok) begin
            alive_d[hit_idx] = 1'b0;
            count_d          = count_q - 6'd1;
          end
          if (frame_tick && at_period) begin
            cnt_d  = '0;
            per_d  = 7'(MIN_PERIOD)
                   + 7'(count_q >> PERIOD_SHIFT);
            anim_d = ~anim_q;
            tick_d = 1'b1;
            if (!drop) begin
              x_d = (state_q == S_MARCH_L)
                  ? x_q - 10'(STEP_X)
                  : x_q + 10'(STEP_X);
            end else begin
              y_d     = y_drop;
              dir_d   = (state_q == S_MARCH_R);
              state_d = (state_q == S_MARCH_R)
                      ? S_MARCH_L : S_MARCH_R;
              if (landing) begin
                state_d = S_LANDED;
                land_d  = 1'b1;
              end
            end
          end else if (frame_tick) begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      S_CLEARED: begin
`ifdef ALIEN_WAVE_RESTART_EN
        if (frame_tick) begin
          if (cnt_q == 7'(RESTART_FRAMES - 1)) begin
            state_d = S_MARCH_R;
            x_d     = 10'(START_X);
            y_d     = 10'(START_Y);
            alive_d = '1;
            count_d = FULL_CNT;
            anim_d  = 1'b0;
            dir_d   = 1'b0;
            clr_d   = 1'b0;
            cnt_d   = '0;
            per_d   = RESET_PER;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
`endif
      end
      S_LANDED: begin
      end
      default: state_d = S_MARCH_R;
    endcase
  end

  // State and datapath registers; Reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_MARCH_R;
      frame_q <= 1'b0;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      alive_q <= '1;
      count_q <= FULL_CNT;
      anim_q  <= 1'b0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      land_q  <= 1'b0;
      cnt_q   <= '0;
      per_q   <= RESET_PER;
    end else begin
      state_q <= state_d;
      frame_q <= frame_clk;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      count_q <= count_d;
      anim_q  <= anim_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      land_q  <= land_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
    end
  end

  assign fleet_x       = x_q;
  assign fleet_y       = y_q;
  assign alive         = alive_q;
  assign alive_count   = count_q;
  assign anim_frame    = anim_q;
  assign fleet_dir     = dir_q;
  assign march_tick    = tick_q;
  assign fleet_cleared = clr_q;
  assign fleet_landed  = land_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Bench for alien_fleet_ctrl: directed march/drop/hit/land runs plus
// random hits and frames, all scored against a behavioural model.
module tb_alien_fleet_ctrl;
  import alien_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fclk;
  logic       hv0, hv1;
  logic [2:0] hr0, hc0, hr1, hc1;

  logic [9:0]  x0, y0, x1, y1;
  logic [39:0] al0, al1;
  logic [5:0]  cnt0, cnt1;
  logic        an0, dr0, tk0, cl0, ld0;
  logic        an1, dr1, tk1, cl1, ld1;

  alien_fleet_ctrl u0 (
    .Clk(clk), .Reset(rst), .frame_clk(fclk),
    .hit_valid(hv0), .hit_row(hr0), .hit_col(hc0),
    .fleet_x(x0), .fleet_y(y0), .alive(al0),
    .alive_count(cnt0), .anim_frame(an0),
    .fleet_dir(dr0), .march_tick(tk0),
    .fleet_cleared(cl0), .fleet_landed(ld0)
  );

  alien_fleet_ctrl #(.START_Y(336)) u1 (
    .Clk(clk), .Reset(rst), .frame_clk(fclk),
    .hit_valid(hv1), .hit_row(hr1), .hit_col(hc1),
    .fleet_x(x1), .fleet_y(y1), .alive(al1),
    .alive_count(cnt1), .anim_frame(an1),
    .fleet_dir(dr1), .march_tick(tk1),
    .fleet_cleared(cl1), .fleet_landed(ld1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference, one slot per instance.
  // mst: 0 marching, 1 cleared, 2 landed.
  int          mx[2], my[2], mdir[2], manim[2];
  int          mcnt[2], mper[2], mcount[2], mst[2];
  int          mtick[2], mclr[2], mland[2];
  logic [39:0] mal[2];
  int          sy[2] = '{48, 336};
  int          mprev;

  int nt0 = 0;
  int nt1_post = 0;
  logic ld1_prev = 1'b0;

  function automatic void ext(input logic [39:0] a,
                              output int lc,
                              output int rc,
                              output int br);
    bit f = 0;
    lc = 0; rc = 0; br = 0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 5; r++)
        if (a[r*8+c]) begin
          if (!f) begin lc = c; f = 1; end
          rc = c;
          if (r > br) br = r;
        end
  endfunction

  task automatic mreset(input int i);
    mx[i] = 64; my[i] = sy[i]; mdir[i] = 0;
    manim[i] = 0; mcnt[i] = 0; mper[i] = 22;
    mal[i] = '1; mcount[i] = 40; mst[i] = 0;
    mtick[i] = 0; mclr[i] = 0; mland[i] = 0;
  endtask

  task automatic mstep(input int i, input bit tick,
                       input bit hv, input int hr,
                       input int hc);
    int lc, rc, br, pc;
    logic [39:0] pre;
    bit drop;
    mtick[i] = 0;
    if (mst[i] == 0) begin
      if (mcount[i] == 0) begin
        mst[i] = 1; mclr[i] = 1; mcnt[i] = 0;
      end else begin
        pre = mal[i];
        pc  = mcount[i];
        if (hv && hr < 5 && mal[i][hr*8+hc]) begin
          mal[i][hr*8+hc] = 1'b0;
          mcount[i]--;
        end
        if (tick) begin
          mcnt[i]++;
          if (mcnt[i] == mper[i]) begin
            mcnt[i]  = 0;
            mper[i]  = 2 + pc / 2;
            manim[i] = 1 - manim[i];
            mtick[i] = 1;
            ext(pre, lc, rc, br);
            if (mdir[i] == 0) drop = (mx[i] + rc*24 + 17 > 639);
            else              drop = (mx[i] + lc*24 - 2 < 0);
            if (!drop) mx[i] += (mdir[i] == 0) ? 2 : -2;
            else begin
              my[i] += 8;
              mdir[i] = 1 - mdir[i];
              if (my[i] + br*20 + 15 >= 440) begin
                mst[i] = 2; mland[i] = 1;
              end
            end
          end
        end
      end
    end else if (mst[i] == 1) begin
`ifdef ALIEN_WAVE_RESTART_EN
      if (tick) begin
        mcnt[i]++;
        if (mcnt[i] == 120) begin
          mreset(i);
        end
      end
`endif
    end
  endtask

  task automatic cmp_all();
    chk("u0.x", x0, mx[0]);
    chk("u0.y", y0, my[0]);
    chk("u0.alive", al0, mal[0]);
    chk("u0.count", cnt0, mcount[0]);
    chk("u0.anim", an0, manim[0]);
    chk("u0.dir", dr0, mdir[0]);
    chk("u0.tick", tk0, mtick[0]);
    chk("u0.cleared", cl0, mclr[0]);
    chk("u0.landed", ld0, mland[0]);
    chk("u1.x", x1, mx[1]);
    chk("u1.y", y1, my[1]);
    chk("u1.alive", al1, mal[1]);
    chk("u1.count", cnt1, mcount[1]);
    chk("u1.anim", an1, manim[1]);
    chk("u1.dir", dr1, mdir[1]);
    chk("u1.tick", tk1, mtick[1]);
    chk("u1.cleared", cl1, mclr[1]);
    chk("u1.landed", ld1, mland[1]);
  endtask

  // One clock: advance model with current inputs, then score DUTs.
  task automatic cyc();
    bit t;
    t = fclk && !mprev;
    mprev = fclk;
    if (rst) begin
      mreset(0); mreset(1); mprev = 0;
    end else begin
      mstep(0, t, hv0, int'(hr0), int'(hc0));
      mstep(1, t, hv1, int'(hr1), int'(hc1));
    end
    @(posedge clk);
    #1;
    cmp_all();
    if (tk0 === 1'b1) nt0++;
    if (ld1_prev && tk1 === 1'b1) nt1_post++;
    ld1_prev = ld1;
    hv0 = 1'b0;
    hv1 = 1'b0;
  endtask

  task automatic frame();
    fclk = 1'b1; cyc();
    fclk = 1'b0; cyc();
  endtask

  int guard;

  initial begin
    rst = 1'b1; fclk = 1'b0;
    hv0 = 1'b0; hr0 = '0; hc0 = '0;
    hv1 = 1'b0; hr1 = '0; hc1 = '0;
    mprev = 0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (4) cyc();
    chk("rst_x", x0, 64);
    chk("rst_y", y0, 48);
    chk("rst_alive", al0, 40'hFF_FFFF_FFFF);
    chk("rst_count", cnt0, 40);
    chk("rst_flags", {an0, dr0, tk0, cl0, ld0}, 0);

    repeat (21) frame();
    chk("ticks_21", nt0, 0);
    frame();
    chk("ticks_22", nt0, 1);
    chk("x_step1", x0, 66);
    chk("anim_step1", an0, 1);

    repeat (195 * 22) frame();
    chk("x_step196", x0, 456);
    chk("dir_step196", dr0, 0);
    repeat (22) frame();
    chk("drop_y", y0, 56);
    chk("drop_x", x0, 456);
    chk("drop_dir", dr0, 1);

    repeat (21) frame();
    hv0 = 1'b1; hr0 = 3'd0; hc0 = 3'd0;
    frame();
    chk("hitstep_x", x0, 454);
    chk("hitstep_cnt", cnt0, 39);

    for (int r = 0; r < 5; r++) begin
      hv0 = 1'b1; hr0 = 3'(r); hc0 = 3'd7;
      cyc();
    end
    cyc();
    chk("col7_cnt", cnt0, 34);
    hv0 = 1'b1; hr0 = 3'd6; hc0 = 3'd2;
    cyc(); cyc();
    chk("badrow_cnt", cnt0, 34);
    hv0 = 1'b1; hr0 = 3'd0; hc0 = 3'd0;
    cyc(); cyc();
    chk("dead_cnt", cnt0, 34);

    guard = 0;
    while (dr0 !== 1'b0 && guard < 20000) begin
      frame(); guard++;
    end
    while (dr0 !== 1'b1 && guard < 20000) begin
      frame(); guard++;
    end
    chk("wait_budget", guard < 20000, 1);
    chk("rdrop_x", x0, 480);
    chk("rdrop_y", y0, 72);

    chk("low_landed", ld1, 1);
    chk("low_y", y1, 352);
    chk("low_x", x1, 0);
    chk("low_post_ticks", nt1_post, 0);
    hv1 = 1'b1; hr1 = 3'd2; hc1 = 3'd3;
    cyc(); cyc();
    chk("low_hit_ignored", cnt1, 40);

    for (int k = 0; k < 1500; k++) begin
      fclk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        hv0 = 1'b1;
        hr0 = 3'($urandom_range(0, 7));
        hc0 = 3'($urandom_range(0, 7));
      end
      cyc();
    end
    fclk = 1'b0;
    cyc();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 8; c++) begin
        hv0 = 1'b1; hr0 = 3'(r); hc0 = 3'(c);
        cyc();
      end
    repeat (3) cyc();
    chk("clr_flag", cl0, 1);
    chk("clr_cnt", cnt0, 0);
    nt0 = 0;
    repeat (60) frame();
    chk("clr_no_tick", nt0, 0);
    repeat (61) frame();
`ifdef ALIEN_WAVE_RESTART_EN
    chk("wave_alive", al0, 40'hFF_FFFF_FFFF);
    chk("wave_x", x0, 64);
    chk("wave_clr", cl0, 0);
`else
    chk("clr_terminal", cl0, 1);
    chk("clr_no_tick2", nt0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
